// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: LANES x ACC_WIDTH partial-sum store with in-buffer
// read-modify-write accumulation, a zero-sweep clear FSM and a registered
// read port. Optional macro PSUM_SAT_EN selects saturating lane adds with a
// sticky ovf_flag; when it is undefined, adds wrap and ovf_flag is tied 0.
module psum_accum_buffer #(
   parameter int LANES      = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int DEPTH      = 1024,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_start,
   output logic                       clr_busy,
   input  logic                       acc_en,
   output logic                       acc_ready,
   input  logic                       acc_first,
   input  logic [ADDR_WIDTH-1:0]      acc_addr,
   input  logic [LANES-1:0]           acc_mask,
   input  logic [LANES*ACC_WIDTH-1:0] acc_data,
   input  logic                       rd_en,
   input  logic [ADDR_WIDTH-1:0]      raddr,
   output logic [LANES*ACC_WIDTH-1:0] rdata,
   output logic                       rvalid,
   output logic                       ovf_flag
);
   localparam int W = LANES * ACC_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  accept, clr_accept;

   // stage-1 op: registered request plus the old (or forwarded) entry value
   logic                  s1_vld, s1_first;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [LANES-1:0]      s1_mask;
   logic [W-1:0]          s1_data, s1_old, s1_new;

   logic [W-1:0] mem [DEPTH];

   // clr_start wins a tie with acc_en, so the acc op is dropped
   assign clr_accept = acc_ready && clr_start;
   assign accept     = acc_en && acc_ready && !clr_start;

   // next-state and status outputs
   always_comb begin
      state_d   = state_q;
      clr_busy  = 1'b0;
      acc_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            acc_ready = 1'b1;
            if (clr_start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            clr_busy = 1'b1;
            if (cnt_q == LAST) state_d = ST_IDLE;
         end
      endcase
   end

   // state register and sweep counter; counter is zero whenever IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CLEAR && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
         else                                      cnt_q <= '0;
      end
   end

   // per-lane update: keep, overwrite, or add (wrapping or saturating)
`ifdef PSUM_SAT_EN
   logic [LANES-1:0] lane_ovf;
`endif
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [ACC_WIDTH-1:0] old_l, dat_l, sum_l, add_l;
      assign old_l = s1_old[i*ACC_WIDTH +: ACC_WIDTH];
      assign dat_l = s1_data[i*ACC_WIDTH +: ACC_WIDTH];
      assign sum_l = old_l + dat_l;
`ifdef PSUM_SAT_EN
      logic ovf_l;
      // signed overflow: operands share a sign that the sum does not
      assign ovf_l = (old_l[ACC_WIDTH-1] == dat_l[ACC_WIDTH-1]) &&
                     (sum_l[ACC_WIDTH-1] != old_l[ACC_WIDTH-1]);
      assign add_l = !ovf_l ? sum_l :
                     (old_l[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}});
      assign lane_ovf[i] = ovf_l && s1_mask[i] && !s1_first;
`else
      assign add_l = sum_l;
`endif
      assign s1_new[i*ACC_WIDTH +: ACC_WIDTH] =
         !s1_mask[i] ? old_l : (s1_first ? dat_l : add_l);
   end

   // stage 0: capture request and old value, forwarding an in-flight same-address write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         s1_addr  <= '0;
         s1_mask  <= '0;
         s1_data  <= '0;
         s1_old   <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_first <= acc_first;
            s1_addr  <= acc_addr;
            s1_mask  <= acc_mask;
            s1_data  <= acc_data;
            s1_old   <= (s1_vld && s1_addr == acc_addr) ? s1_new : mem[acc_addr];
         end
      end
   end

   // storage writes: stage-1 commit, then the clear sweep
   always_ff @(posedge clk) begin
      if (s1_vld)              mem[s1_addr] <= s1_new;
      if (state_q == ST_CLEAR) mem[cnt_q]   <= '0;
   end

   // registered read-first port; rdata holds when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) rdata <= mem[raddr];
      end
   end

`ifdef PSUM_SAT_EN
   // sticky overflow, cleared by an accepted clear request
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         ovf_flag <= 1'b0;
      else if (s1_vld && |lane_ovf)    ovf_flag <= 1'b1;
      else if (clr_accept)             ovf_flag <= 1'b0;
   end
`else
   assign ovf_flag = 1'b0;
`endif

endmodule
